// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream controller: state encodings,
// read-latency limits and a width helper.
package fifo_rd_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Smallest bit width able to represent 'value' (at least 1).
  function automatic int width_for(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Sized for the deepest legal buffer so the occupancy port width never changes.
  localparam int CNT_WIDTH = width_for(RD_LATENCY_MAX + 2);

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Circular prefetch buffer with occupancy count; depth need not be a power of 2.
// Writes into a full buffer are ignored; clear has priority over everything.
module fifo_rd_prefetch_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full
);

  localparam int PTR_W = width_for(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (count_q == CNT_WIDTH'(DEPTH));
  assign wr_ok   = wr_en && !full && !clr;
  assign rd_ok   = rd_en && (count_q != '0) && !clr;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(rd_ok);
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fifo_rd_stream_ctrl.sv
// Read-side consumer for generic_2clk_fifo: issues pops ahead of demand, tracks
// reads in flight through the memory latency, and presents a valid/ready stream.
module fifo_rd_stream_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_op,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  buf_count,
  output logic                  err_overflow
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int SUM_W     = CNT_WIDTH + 1;

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("fifo_rd_stream_ctrl: RD_LATENCY must be 1 or 2");
  end

  // Stream handshake: a word transfers on any cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_data holds until transferred.

  logic [0:0]            state_q, state_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  inflight;
  logic [SUM_W-1:0]      credit_sum;
  logic                  rd_op;
  logic                  clr;
  logic                  cap_en;
  logic                  pop;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_rdata;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_WIDTH'(pipe_q[i]);
    end
  end

  // Credit counts reads in flight plus words held, so a pop never outruns space.
  always_comb begin
    state_d    = state_q;
    rd_op      = 1'b0;
    clr        = 1'b0;
    credit_sum = {1'b0, inflight} + {1'b0, buf_count};
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          rd_op = !fifo_empty && (credit_sum < SUM_W'(BUF_DEPTH));
        end
      end
      ST_FLUSH: begin
        if (inflight == '0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Held low during reset so no word is popped and then forgotten.
  assign fifo_rd_op = rd_op && !rst;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = fifo_rd_op;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign cap_en       = pipe_q[RD_LATENCY-1] && (state_q == ST_RUN) && !flush;
  assign out_valid    = (state_q == ST_RUN) && (buf_count != '0);
  assign pop          = out_valid && out_ready;
  assign out_data     = out_valid ? buf_rdata : '0;
  assign busy         = (state_q == ST_FLUSH);
  assign err_d        = err_q | (cap_en & buf_full);
  assign err_overflow = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pipe_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      err_q   <= err_d;
    end
  end

  fifo_rd_prefetch_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wr_en  (cap_en),
    .wr_data(mem_rdata),
    .rd_en  (pop),
    .rd_data(buf_rdata),
    .count  (buf_count),
    .full   (buf_full)
  );

endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// Directed bench: instance A uses RD_LATENCY=1, instance B uses RD_LATENCY=2,
// each fed by a simple FIFO/memory model.
module tb_fifo_rd_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        flush_a, flush_b;
  logic        out_ready_a, out_ready_b;
  logic        fifo_empty_a, fifo_empty_b;
  logic        rd_op_a, rd_op_b;
  logic        out_valid_a, out_valid_b;
  logic        busy_a, busy_b;
  logic        err_a, err_b;
  logic [31:0] out_data_a, out_data_b;
  logic [31:0] rdata_a, d1_b, d2_b;
  logic [2:0]  buf_count_a, buf_count_b;

  logic [31:0] stor_a [64];
  logic [31:0] stor_b [64];
  int          wr_ptr_a = 0;
  int          wr_ptr_b = 0;
  int          rd_ptr_a = 0;
  int          rd_ptr_b = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // FIFO/memory model: pointer registered, read data RD_LATENCY cycles after the pop.
  always @(posedge clk) begin
    if (rd_op_a) begin
      rd_ptr_a <= rd_ptr_a + 1;
      rdata_a  <= stor_a[rd_ptr_a[5:0]];
    end
    if (rd_op_b) begin
      rd_ptr_b <= rd_ptr_b + 1;
      d1_b     <= stor_b[rd_ptr_b[5:0]];
    end
    d2_b <= d1_b;
  end

  assign fifo_empty_a = (wr_ptr_a == rd_ptr_a);
  assign fifo_empty_b = (wr_ptr_b == rd_ptr_b);

  fifo_rd_stream_ctrl #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .fifo_empty(fifo_empty_a), .fifo_rd_op(rd_op_a),
    .mem_rdata(rdata_a), .flush(flush_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a),
    .buf_count(buf_count_a), .err_overflow(err_a)
  );

  fifo_rd_stream_ctrl #(.DATA_WIDTH(32), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .fifo_empty(fifo_empty_b), .fifo_rd_op(rd_op_b),
    .mem_rdata(d2_b), .flush(flush_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b),
    .buf_count(buf_count_b), .err_overflow(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] data);
    stor_a[wr_ptr_a[5:0]] = data;
    wr_ptr_a++;
  endtask

  task automatic push_b(input logic [31:0] data);
    stor_b[wr_ptr_b[5:0]] = data;
    wr_ptr_b++;
  endtask

  // Collect n words from instance A, expecting first, first+1, ...
  task automatic expect_stream(input logic [31:0] first, input int n, input int budget,
                               input bit chk_gap);
    int   got = 0;
    int   gaps = 0;
    int   cyc = 0;
    int   maxc = 0;
    bit   started = 1'b0;
    while (got < n && cyc < budget) begin
      if (int'(buf_count_a) > maxc) maxc = int'(buf_count_a);
      if (out_valid_a) begin
        check("stream_data", out_data_a, first + 32'(got));
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    check("stream_count", 32'(got), 32'(n));
    check("stream_max_buf_count_le3", {31'b0, maxc <= 3}, 32'd1);
    if (chk_gap) check("stream_gaps", 32'(gaps), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int cyc;
    rst_a = 1'b1; rst_b = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0;
    out_ready_a = 1'b0; out_ready_b = 1'b0;

    // Reset / idle
    repeat (3) tick();
    check("rst_rd_op", {30'b0, rd_op_a, rd_op_b}, 32'd0);
    check("rst_out_valid", {30'b0, out_valid_a, out_valid_b}, 32'd0);
    check("rst_out_data", out_data_a | out_data_b, 32'd0);
    check("rst_busy_err", {28'b0, busy_a, busy_b, err_a, err_b}, 32'd0);
    check("rst_buf_count", {26'b0, buf_count_a, buf_count_b}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    pops = 0;
    repeat (20) begin
      tick();
      pops += int'(rd_op_a) + int'(rd_op_b);
    end
    check("idle_no_pops", 32'(pops), 32'd0);

    // Single word, RD_LATENCY=1
    out_ready_a = 1'b1;
    push_a(32'hA5A5_0001);
    #1;
    check("single_issue", {31'b0, rd_op_a}, 32'd1);
    check("single_valid_c0", {31'b0, out_valid_a}, 32'd0);
    tick();
    check("single_no_reissue", {31'b0, rd_op_a}, 32'd0);
    check("single_valid_c1", {31'b0, out_valid_a}, 32'd0);
    tick();
    check("single_valid_c2", {31'b0, out_valid_a}, 32'd1);
    check("single_data", out_data_a, 32'hA5A5_0001);
    check("single_count_c2", {29'b0, buf_count_a}, 32'd1);
    tick();
    check("single_valid_c3", {31'b0, out_valid_a}, 32'd0);
    check("single_count_c3", {29'b0, buf_count_a}, 32'd0);

    // Streaming 16 words with out_ready held high
    tick();
    for (int i = 0; i < 16; i++) push_a(32'(i));
    #1;
    expect_stream(32'd0, 16, 80, 1'b1);
    repeat (3) tick();

    // Backpressure
    out_ready_a = 1'b0;
    for (int i = 0; i < 16; i++) push_a(32'(i));
    #1;
    pops = 0;
    repeat (10) begin
      pops += int'(rd_op_a);
      tick();
    end
    check("bp_pops", 32'(pops), 32'd3);
    check("bp_buf_count", {29'b0, buf_count_a}, 32'd3);
    check("bp_head", out_data_a, 32'd0);
    out_ready_a = 1'b1;
    expect_stream(32'd0, 16, 80, 1'b0);
    check("bp_err_overflow", {31'b0, err_a}, 32'd0);
    repeat (3) tick();

    // Flush with returns in flight, RD_LATENCY=2
    out_ready_b = 1'b1;
    for (int i = 0; i < 16; i++) push_b(32'h200 + 32'(i));
    #1;
    repeat (6) tick();
    check("flush_pre_data", out_data_b, 32'h203);
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    check("flush_valid_f1", {31'b0, out_valid_b}, 32'd0);
    check("flush_busy_f1", {31'b0, busy_b}, 32'd1);
    check("flush_count_f1", {29'b0, buf_count_b}, 32'd0);
    check("flush_rd_op_f1", {31'b0, rd_op_b}, 32'd0);
    tick();
    check("flush_busy_f2", {31'b0, busy_b}, 32'd1);
    check("flush_rd_op_f2", {31'b0, rd_op_b}, 32'd0);
    tick();
    check("flush_busy_f3", {31'b0, busy_b}, 32'd0);
    check("flush_rd_op_f3", {31'b0, rd_op_b}, 32'd1);
    cyc = 0;
    while (!out_valid_b && cyc < 20) begin
      tick();
      cyc++;
    end
    check("flush_resume_latency", 32'(cyc), 32'd3);
    check("flush_resume_data", out_data_b, 32'h206);
    check("flush_err_overflow", {31'b0, err_b}, 32'd0);

    // Async reset mid-stream, RD_LATENCY=1
    out_ready_a = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) push_a(32'h300 + 32'(i));
    #1;
    repeat (3) tick();
    check("arst_pre_count", {29'b0, buf_count_a}, 32'd2);
    #3;
    rst_a = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid_a}, 32'd0);
    check("arst_count", {29'b0, buf_count_a}, 32'd0);
    check("arst_rd_op", {31'b0, rd_op_a}, 32'd0);
    check("arst_data", out_data_a, 32'd0);
    @(posedge clk);
    #4;
    rst_a = 1'b0;
    out_ready_a = 1'b1;
    tick();
    expect_stream(32'h303, 13, 80, 1'b0);
    check("arst_err_overflow", {31'b0, err_a}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
